edge_trig_mc: RTL and testbench

Multi-channel, width-parametrised edge trigger for the scope acquisition path. Each ADC channel has its own fully synchronous hysteresis comparator. A holdoff counter and an arm/trigger state machine then produce a single-cycle trigger pulse for the capture controller. It replaces the single-channel, async-edge trigger with a design that has one clock domain, explicit arming, holdoff, and source selection.

---
 rtl/edge_trig_pkg.sv | 24 ++
 rtl/edge_trig_mc_hyst_comp.sv | 57 +++++
 rtl/edge_trig_mc.sv | 170 +++++++++++++++++
 tb/tb_edge_trig_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_trig_pkg.sv
// +--------------------------------------------------------------------+
// | edge_trig_pkg : trigger type codes and FSM state encoding           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package edge_trig_pkg;

  localparam logic [2:0] TRIG_NEVER = 3'd0;
  localparam logic [2:0] TRIG_RISE  = 3'd1;
  localparam logic [2:0] TRIG_FALL  = 3'd2;
  localparam logic [2:0] TRIG_ANY   = 3'd3;
  localparam logic [2:0] TRIG_AUTO  = 3'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLDOFF   = 2'd1,
    ARMED     = 2'd2,
    TRIGGERED = 2'd3
  } trig_state_t;

endpackage

`default_nettype wire

// File: rtl/edge_trig_mc_hyst_comp.sv
// +--------------------------------------------------------------------+
// | hyst_comp : per-channel hysteresis comparator with registered edges |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hyst_comp #(
  parameter int DATA_W = 14
) (
  input  logic              clkIn,
  input  logic              rstIn,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] upper,
  input  logic [DATA_W-1:0] lower,
  output logic              level,
  output logic              valid,
  output logic              rise,
  output logic              fall
);

  logic w_above;
  logic w_below;

  assign w_above = (sample > upper);
  assign w_below = (sample < lower);

  // The first decided sample after a clear only seeds the level state.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      level <= 1'b0;
      valid <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (clear) begin
      level <= 1'b0;
      valid <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (w_above) begin
        level <= 1'b1;
        valid <= 1'b1;
        rise  <= valid && !level;
      end else if (w_below) begin
        level <= 1'b0;
        valid <= 1'b1;
        fall  <= valid && level;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_trig_mc.sv
// +--------------------------------------------------------------------+
// | edge_trig_mc : multi-channel hysteresis edge trigger with holdoff   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module edge_trig_mc
  import edge_trig_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int NUM_CH    = 2,
  parameter int HOLDOFF_W = 16,
  parameter int SEL_W     = 1
) (
  input  logic                     clkIn,
  input  logic                     rstIn,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0]        trigLvl,
  input  logic [DATA_W-1:0]        trigHyst,
  input  logic [2:0]               trigType,
  input  logic [SEL_W-1:0]         trigSrc,
  input  logic [HOLDOFF_W-1:0]     holdoff,
  input  logic                     arm,
  input  logic                     disarm,
  output logic                     q,
  output logic                     armed,
  output logic                     trigged,
  output logic [SEL_W-1:0]         trigCh
);

  trig_state_t r_state;

  logic [NUM_CH*DATA_W-1:0] r_adc;
  logic [DATA_W-1:0]        r_shLvl;
  logic [DATA_W-1:0]        r_shHyst;
  logic [2:0]               r_shType;
  logic [SEL_W-1:0]         r_shSrc;
  logic [HOLDOFF_W-1:0]     r_cnt;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_upper;
  logic [DATA_W-1:0] w_lower;
  logic              w_accept;
  logic              w_fire;
  logic              w_srcRise;
  logic              w_srcFall;
  logic              w_srcOk;
  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) r_adc <= '0;
    else       r_adc <= adc_data;
  end

  // One extra bit exposes overflow on the sum and borrow on the difference.
  assign w_sum   = {1'b0, r_shLvl} + {1'b0, r_shHyst};
  assign w_diff  = {1'b0, r_shLvl} - {1'b0, r_shHyst};
  assign w_upper = w_sum[DATA_W]  ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
  assign w_lower = w_diff[DATA_W] ? '0             : w_diff[DATA_W-1:0];

  assign w_accept = arm && !disarm && ((r_state == IDLE) || (r_state == TRIGGERED));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hyst_comp #(
      .DATA_W (DATA_W)
    ) u_comp (
      .clkIn  (clkIn),
      .rstIn  (rstIn),
      .clear  (w_accept),
      .sample (r_adc[g*DATA_W +: DATA_W]),
      .upper  (w_upper),
      .lower  (w_lower),
      .level  (w_level[g]),
      .valid  (w_valid[g]),
      .rise   (w_rise[g]),
      .fall   (w_fall[g])
    );
  end

  // Source values outside the channel range simply never match.
  always_comb begin
    w_srcRise = 1'b0;
    w_srcFall = 1'b0;
    w_srcOk   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_shSrc == SEL_W'(i)) begin
        w_srcRise = w_rise[i] && w_level[i]  && w_valid[i];
        w_srcFall = w_fall[i] && !w_level[i] && w_valid[i];
        w_srcOk   = 1'b1;
      end
    end
  end

  always_comb begin
    w_fire = 1'b0;
    case (r_shType)
      TRIG_RISE: w_fire = w_srcRise;
      TRIG_FALL: w_fire = w_srcFall;
      TRIG_ANY:  w_fire = w_srcRise || w_srcFall;
      TRIG_AUTO: w_fire = w_srcOk;
      default:   w_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state  <= IDLE;
      r_shLvl  <= '0;
      r_shHyst <= '0;
      r_shType <= TRIG_NEVER;
      r_shSrc  <= '0;
      r_cnt    <= '0;
      q        <= 1'b0;
      armed    <= 1'b0;
      trigged  <= 1'b0;
      trigCh   <= '0;
    end else begin
      q <= 1'b0;
      if (w_accept) begin
        r_shLvl  <= trigLvl;
        r_shHyst <= trigHyst;
        r_shType <= trigType;
        r_shSrc  <= trigSrc;
        r_cnt    <= holdoff;
      end
      if (disarm && (r_state != IDLE)) begin
        r_state <= IDLE;
        armed   <= 1'b0;
        trigged <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) r_state <= HOLDOFF;
          end
          HOLDOFF: begin
            if (r_cnt == '0) begin
              r_state <= ARMED;
              armed   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - HOLDOFF_W'(1);
            end
          end
          ARMED: begin
            if (w_fire) begin
              r_state <= TRIGGERED;
              q       <= 1'b1;
              armed   <= 1'b0;
              trigged <= 1'b1;
              trigCh  <= r_shSrc;
            end
          end
          TRIGGERED: begin
            if (w_accept) begin
              r_state <= HOLDOFF;
              trigged <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_trig_mc.sv
// +--------------------------------------------------------------------+
// | tb_edge_trig_mc : scoreboard bench for the multi-channel trigger    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_edge_trig_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] adc = '0;
  logic [13:0] lvl = '0;
  logic [13:0] hyst = '0;
  logic [2:0]  typ = '0;
  logic        src = 1'b0;
  logic [15:0] hold = '0;
  logic        arm = 1'b0;
  logic        disarm = 1'b0;
  logic        q;
  logic        armed;
  logic        trigged;
  logic        trigCh;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int expQ[$];
  int gotQ[$];

  edge_trig_mc #(
    .DATA_W    (14),
    .NUM_CH    (2),
    .HOLDOFF_W (16),
    .SEL_W     (1)
  ) dut (
    .clkIn    (clk),
    .rstIn    (rst),
    .adc_data (adc),
    .trigLvl  (lvl),
    .trigHyst (hyst),
    .trigType (typ),
    .trigSrc  (src),
    .holdoff  (hold),
    .arm      (arm),
    .disarm   (disarm),
    .q        (q),
    .armed    (armed),
    .trigged  (trigged),
    .trigCh   (trigCh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (q === 1'b1) gotQ.push_back(cyc);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if ({q, armed, trigged, trigCh} !== 4'b0000) begin errors++;
      $display("FAIL reset_outputs got=%b exp=0000", {q, armed, trigged, trigCh}); end
  endtask

  task automatic test_rise;
    expQ.delete(); gotQ.delete();
    lvl = 14'd8192; hyst = 14'd100; typ = 3'd1; src = 1'b0; hold = 16'd0;
    adc[13:0] = 14'd8000; adc[27:14] = 14'd0;
    arm = 1'b1; tick; arm = 1'b0; tick;
    checks++; if (armed !== 1'b1) begin errors++;
      $display("FAIL rise_armed got=%b exp=1", armed); end
    for (int v = 8000; v <= 8400; v += 50) begin
      adc[13:0] = 14'(v);
      if (v == 8300) expQ.push_back(cyc + 3);
      tick;
    end
    repeat (4) tick;
    checks++; if (gotQ.size() != expQ.size()) begin errors++;
      $display("FAIL rise_qcount got=%0d exp=%0d", gotQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (gotQ[i] != expQ[i]) begin errors++;
        $display("FAIL rise_qcycle got=%0d exp=%0d", gotQ[i], expQ[i]); end
    end
    checks++; if ({armed, trigged, trigCh} !== 3'b010) begin errors++;
      $display("FAIL rise_status got=%b exp=010", {armed, trigged, trigCh}); end
  endtask

  task automatic test_dead_zone;
    int lows;
    lows = 0;
    expQ.delete(); gotQ.delete();
    adc[13:0] = 14'd8150;
    arm = 1'b1; tick; arm = 1'b0; tick;
    for (int i = 0; i < 1000; i++) begin
      adc[13:0] = (i % 2 == 0) ? 14'd8250 : 14'd8150;
      tick;
      if (armed !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++;
      $display("FAIL dead_armed_drops got=%0d exp=0", lows); end
    checks++; if (gotQ.size() != 0) begin errors++;
      $display("FAIL dead_qcount got=%0d exp=0", gotQ.size()); end
    disarm = 1'b1; tick; disarm = 1'b0;
    checks++; if ({armed, trigged} !== 2'b00) begin errors++;
      $display("FAIL dead_disarm got=%b exp=00", {armed, trigged}); end
  endtask

  task automatic test_fall_ch1;
    expQ.delete(); gotQ.delete();
    typ = 3'd2; src = 1'b1;
    adc[27:14] = 14'd9000; adc[13:0] = 14'd0;
    arm = 1'b1; tick; arm = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      adc[27:14] = 14'(9000 - 100 * i);
      adc[13:0]  = (i % 2 == 1) ? 14'd16000 : 14'd0;
      if (9000 - 100 * i == 8000) expQ.push_back(cyc + 3);
      tick;
    end
    repeat (4) tick;
    checks++; if (gotQ.size() != expQ.size()) begin errors++;
      $display("FAIL fall_qcount got=%0d exp=%0d", gotQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (gotQ[i] != expQ[i]) begin errors++;
        $display("FAIL fall_qcycle got=%0d exp=%0d", gotQ[i], expQ[i]); end
    end
    checks++; if ({trigged, trigCh} !== 2'b11) begin errors++;
      $display("FAIL fall_status got=%b exp=11", {trigged, trigCh}); end
  endtask

  task automatic test_holdoff;
    int k;
    expQ.delete(); gotQ.delete();
    disarm = 1'b1; tick; disarm = 1'b0; tick;
    typ = 3'd1; src = 1'b0; hold = 16'd10; adc[13:0] = 14'd8000;
    k = cyc;
    arm = 1'b1; tick; arm = 1'b0;
    while (cyc < k + 5) tick;
    adc[13:0] = 14'd8400;
    while (cyc < k + 10) tick;
    adc[13:0] = 14'd8000;
    tick;
    checks++; if (armed !== 1'b0) begin errors++;
      $display("FAIL holdoff_early_armed got=%b exp=0", armed); end
    tick;
    checks++; if (armed !== 1'b1) begin errors++;
      $display("FAIL holdoff_armed got=%b exp=1", armed); end
    while (cyc < k + 25) tick;
    adc[13:0] = 14'd8400;
    expQ.push_back(cyc + 3);
    repeat (5) tick;
    checks++; if (gotQ.size() != expQ.size()) begin errors++;
      $display("FAIL holdoff_qcount got=%0d exp=%0d", gotQ.size(), expQ.size()); end
    else begin
      checks++; if (gotQ[0] != expQ[0]) begin errors++;
        $display("FAIL holdoff_qcycle got=%0d exp=%0d", gotQ[0], expQ[0]); end
    end
  endtask

  task automatic test_sat_auto;
    int lows;
    lows = 0;
    expQ.delete(); gotQ.delete();
    disarm = 1'b1; tick; disarm = 1'b0; tick;
    lvl = 14'd16300; hyst = 14'd200; typ = 3'd1; src = 1'b0; hold = 16'd0;
    adc[13:0] = 14'd0;
    arm = 1'b1; tick; arm = 1'b0;
    repeat (3) tick;
    adc[13:0] = 14'd16383;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (armed !== 1'b1) lows++;
    end
    checks++; if (gotQ.size() != 0 || lows != 0) begin errors++;
      $display("FAIL sat_no_trigger got=q%0d/drops%0d exp=0/0", gotQ.size(), lows); end
    disarm = 1'b1; tick; disarm = 1'b0; tick;
    typ = 3'd4; src = 1'b1;
    expQ.push_back(cyc + 3);
    arm = 1'b1; tick; arm = 1'b0;
    repeat (4) tick;
    checks++; if (gotQ.size() != expQ.size()) begin errors++;
      $display("FAIL auto_qcount got=%0d exp=%0d", gotQ.size(), expQ.size()); end
    else begin
      checks++; if (gotQ[0] != expQ[0]) begin errors++;
        $display("FAIL auto_qcycle got=%0d exp=%0d", gotQ[0], expQ[0]); end
    end
    checks++; if ({trigged, trigCh} !== 2'b11) begin errors++;
      $display("FAIL auto_status got=%b exp=11", {trigged, trigCh}); end
  endtask

  task automatic test_reset_disarm;
    int k;
    expQ.delete(); gotQ.delete();
    typ = 3'd0; hold = 16'd20;
    k = cyc;
    arm = 1'b1; tick; arm = 1'b0;
    checks++; if ({armed, trigged} !== 2'b00) begin errors++;
      $display("FAIL rearm_clear got=%b exp=00", {armed, trigged}); end
    while (cyc < k + 21) tick;
    checks++; if (armed !== 1'b0) begin errors++;
      $display("FAIL rearm_holdoff_early got=%b exp=0", armed); end
    tick;
    checks++; if (armed !== 1'b1) begin errors++;
      $display("FAIL rearm_holdoff_armed got=%b exp=1", armed); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({q, armed, trigged, trigCh} !== 4'b0000) begin errors++;
      $display("FAIL async_reset got=%b exp=0000", {q, armed, trigged, trigCh}); end
    @(negedge clk); rst = 1'b0;
    tick;
    typ = 3'd4; hold = 16'd0;
    arm = 1'b1; disarm = 1'b1; tick; arm = 1'b0; disarm = 1'b0;
    repeat (4) tick;
    checks++; if ({armed, trigged} !== 2'b00 || gotQ.size() != 0) begin errors++;
      $display("FAIL arm_disarm got=%b/q%0d exp=00/q0", {armed, trigged}, gotQ.size()); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst = 1'b0;
    tick;
    test_rise;
    test_dead_zone;
    test_fall_ch1;
    test_holdoff;
    test_sat_auto;
    test_reset_disarm;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d limit=20000", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
